mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Lets instruction fetch and data access share one memory port through a ready handshake.
- Produces the PC-write, IR-write, register-write and PC-source selects that replace the per-cycle yC1/yC2 enables at chip level.
- Also counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- TIMEOUT, 16, maximum wait cycles for mem_ready in FETCH or MEM before trapping.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous reset, active low
- run  input  1  level; start and keep sequencing
- INT  input  1  level interrupt request; sampled only at retire
- opCode  input  7  ins[6:0] from the instruction register
- zero  input  1  ALU zero flag, valid in EXEC
- mem_ready  input  1  shared memory completes the current access this cycle
- mem_sel  output  1  0 = PC drives memory address, 1 = ALU result drives it
- mem_rd  output  1  memory read request
- mem_wr  output  1  memory write request
- ir_we  output  1  load instruction register
- reg_we  output  1  register file write enable
- Mem2Reg  output  1  writeback selects memory data
- wb_pc4  output  1  writeback selects PCp4 (JAL link)
- ALUSrc  output  1  ALU operand b = immediate
- pc_we  output  1  PC register write enable
- pc_src  output  2  00 PCp4, 01 branch target, 10 jump target, 11 entryPoint
- busy  output  1  state is not IDLE and not TRAP
- trap  output  1  sticky error flag
- trap_cause  output  2  01 illegal opcode, 10 memory timeout
- retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0, retired=0, trap=0, trap_cause=00.
  - All enable and select outputs are 0 immediately.
  - A reset in the middle of an instruction aborts it with no further writes.
- Output timing:
  - Control outputs are combinational from state, latched class, mem_ready, zero and INT.
  - Counters, class and trap are registered.
- Opcode classes (latched in DECODE):
  - R 0110011
  - I 0010011
  - LW 0000011
  - SW 0100011
  - BEQ 1100011
  - JAL 1101111
  - anything else is illegal.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH:
  - mem_sel=0, mem_rd=1.
  - On mem_ready: ir_we=1 in the same cycle, clear wait counter, go to DECODE.
  - Otherwise increment wait counter; when it reaches TIMEOUT-1 without ready, go to TRAP with cause 10.
- DECODE:
  - One cycle; latch class.
  - Illegal class goes to TRAP with cause 01, with no write of any kind.
  - Otherwise go to EXEC.
- EXEC:
  - One cycle; ALUSrc=1 for I, LW, SW.
  - R and I go to WB; LW and SW go to MEM; JAL goes to WB.
  - BEQ retires here: pc_we=1, pc_src=01 if zero=1, else 00.
- MEM:
  - mem_sel=1; mem_rd=1 for LW, mem_wr=1 for SW.
  - Waits on mem_ready with the same timeout rule as FETCH.
  - LW goes to WB on ready.
  - SW retires in the ready cycle: pc_we=1, pc_src=00.
- WB:
  - One cycle; reg_we=1; Mem2Reg=1 for LW; wb_pc4=1 for JAL.
  - Retires: pc_we=1, pc_src=10 for JAL, else 00.
- Retire cycle (any of the above):
  - retired increments by 1, wrapping at 2^CNT_W.
  - If INT=1 in that cycle, pc_src is forced to 11; the instruction's own register or memory write still occurs.
  - Next state is FETCH if run=1, else IDLE.
- Deasserting run never aborts an instruction in flight.
- TRAP:
  - All enables 0, trap=1, busy=0.
  - Stays until reset; run and INT are ignored.
- Latency with mem_ready=1 every cycle:
  - R/I/JAL 4 cycles, LW 5, SW 4, BEQ 3.
- The PC never updates outside a retire cycle.
- mem_rd and mem_wr are never high simultaneously.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - opcode constants
  - pc_src encodings
  - trap cause codes.
- One sub-module, mc_opclass: combinational 7-bit opCode to one-hot class plus illegal flag, reusable by yC1 later.

Test Plan:
1. Reset, run=1, opCode=0110011, mem_ready=1 always -> ir_we at cycle 1; reg_we and pc_we (pc_src=00) at cycle 4; retired=1.
2. LW 0000011 with mem_ready low for 3 cycles in MEM -> mem_sel=1 and mem_rd held 4 cycles; Mem2Reg=reg_we=1 in WB; total 8 cycles.
3. BEQ with zero=1, then BEQ with zero=0 -> pc_src=01, then 00, in EXEC; no reg_we either time; retired=2.
4. JAL with INT=1 during WB -> reg_we=1, wb_pc4=1, pc_src=11, pc_we=1.
5. opCode=1111111 -> TRAP after DECODE with trap_cause=01, no pc_we/reg_we/mem_wr; mem_ready stuck low (TIMEOUT=16) -> trap_cause=10 after 16 FETCH cycles.
6. rst_n pulsed low mid-MEM of SW -> mem_wr drops immediately, state IDLE, retired=0; deassert run mid-instruction -> instruction completes, then IDLE, busy=0.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    // ins[6:0] opcodes recognised by the sequencer
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    // One-hot instruction class; all-zero means illegal
    typedef struct packed {
        logic r;
        logic i;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
    } opclass_t;

    localparam logic [1:0] PcSrcPc4    = 2'b00;
    localparam logic [1:0] PcSrcBranch = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcEntry  = 2'b11;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

endpackage

// File: rtl/mc_sequencer_if.sv
// Control/handshake bundle between the sequencer and the datapath/memory.
interface mc_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             INT;
    logic [6:0]       opCode;
    logic             zero;
    logic             mem_ready;
    logic             mem_sel;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_we;
    logic             reg_we;
    logic             Mem2Reg;
    logic             wb_pc4;
    logic             ALUSrc;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             busy;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  run, INT, opCode, zero, mem_ready,
        output mem_sel, mem_rd, mem_wr, ir_we, reg_we, Mem2Reg, wb_pc4, ALUSrc,
        output pc_we, pc_src, busy, trap, trap_cause, retired
    );

    // Datapath / memory side
    modport slave (
        output run, INT, opCode, zero, mem_ready,
        input  mem_sel, mem_rd, mem_wr, ir_we, reg_we, Mem2Reg, wb_pc4, ALUSrc,
        input  pc_we, pc_src, busy, trap, trap_cause, retired
    );

endinterface

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: 7-bit opcode to one-hot class plus illegal flag.
module mc_opclass
    import mc_sequencer_pkg::*;
(
    input  logic [6:0] opCode,
    output opclass_t   cls,
    output logic       illegal
);

    // Decode opcode to one-hot class
    always_comb begin
        cls = '0;
        case (opCode)
            OpR:     cls.r   = 1'b1;
            OpI:     cls.i   = 1'b1;
            OpLw:    cls.lw  = 1'b1;
            OpSw:    cls.sw  = 1'b1;
            OpBeq:   cls.beq = 1'b1;
            OpJal:   cls.jal = 1'b1;
            default: cls     = '0;
        endcase
        illegal = ~|cls;
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with retire counter and trap.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input logic            clk,
    input logic            rst_n,
    mc_sequencer_if.master bus
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    opclass_t         class_q, class_d;
    logic [1:0]       cause_q, cause_d;
    logic             trap_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    opclass_t         dec_cls;
    logic             dec_illegal;

    mc_opclass u_opclass (
        .opCode  (bus.opCode),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    // State, wait counter, latched class, trap and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            class_q   <= '0;
            cause_q   <= CauseNone;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            class_q   <= class_d;
            cause_q   <= cause_d;
            trap_q    <= trap_q | (state_d == StTrap);
            retired_q <= retire ? retired_q + CNT_W'(1) : retired_q;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        class_d     = class_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        bus.mem_sel = 1'b0;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.ir_we   = 1'b0;
        bus.reg_we  = 1'b0;
        bus.Mem2Reg = 1'b0;
        bus.wb_pc4  = 1'b0;
        bus.ALUSrc  = 1'b0;
        bus.pc_we   = 1'b0;
        bus.pc_src  = PcSrcPc4;
        unique case (state_q)
            StIdle: begin
                if (bus.run) state_d = StFetch;
            end
            StFetch: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    wait_d    = '0;
                    state_d   = StDecode;
                end else if (wait_q == WaitMax) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                class_d = dec_cls;
                if (dec_illegal) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                bus.ALUSrc = class_q.i | class_q.lw | class_q.sw;
                if (class_q.beq) begin
                    retire     = 1'b1;
                    bus.pc_src = bus.zero ? PcSrcBranch : PcSrcPc4;
                end else if (class_q.lw || class_q.sw) begin
                    state_d = StMem;
                end else if (class_q.r || class_q.i || class_q.jal) begin
                    state_d = StWb;
                end else begin
                    // Unreachable: DECODE never passes an illegal class
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end
            end
            StMem: begin
                bus.mem_sel = 1'b1;
                bus.mem_rd  = class_q.lw;
                bus.mem_wr  = class_q.sw;
                if (bus.mem_ready) begin
                    wait_d = '0;
                    if (class_q.sw) retire = 1'b1;
                    else            state_d = StWb;
                end else if (wait_q == WaitMax) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                bus.reg_we  = 1'b1;
                bus.Mem2Reg = class_q.lw;
                bus.wb_pc4  = class_q.jal;
                bus.pc_src  = class_q.jal ? PcSrcJump : PcSrcPc4;
                retire      = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Interrupt redirects the PC only at retire; the instruction's own writes still occur
        if (retire) begin
            bus.pc_we = 1'b1;
            if (bus.INT) bus.pc_src = PcSrcEntry;
            state_d = bus.run ? StFetch : StIdle;
        end
    end

    // Status outputs
    always_comb begin
        bus.busy       = (state_q != StIdle) && (state_q != StTrap);
        bus.trap       = trap_q;
        bus.trap_cause = cause_q;
        bus.retired    = retired_q;
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an instruction-level model.
module tb_mc_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Step kinds within an instruction
    localparam int KF = 0, KD = 1, KE = 2, KM = 3, KW = 4;
    // Model modes
    localparam int MIdle = 0, MRun = 1, MTrap = 2;

    typedef struct packed {
        logic       mem_sel, mem_rd, mem_wr, ir_we, reg_we, m2r, wb_pc4, alusrc, pc_we;
        logic [1:0] pc_src;
        logic       busy, trap;
        logic [1:0] cause;
    } out_t;

    typedef struct {
        int         cycles, first_ir, n_fetch, n_mem_rd, n_mem_wr, n_reg_we, n_pc_we;
        logic       ret_reg_we, ret_m2r, ret_wb_pc4, saw_trap;
        logic [1:0] ret_src;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;
    int   total = 0;
    int   bad   = 0;

    int          m_mode  = MIdle;
    int          m_step  = 0;
    int          m_wait  = 0;
    logic [6:0]  m_op    = '0;
    logic [31:0] m_ret   = '0;
    logic [1:0]  m_cause = '0;

    mc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mc_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles per instruction with an always-ready memory; 0 marks illegal
    function automatic int cls_len(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_JAL: return 4;
            OP_SW:              return 4;
            OP_LW:              return 5;
            OP_BEQ:             return 3;
            default:            return 0;
        endcase
    endfunction

    function automatic int kind_at(input logic [6:0] op, input int step);
        if (step == 0) return KF;
        if (step == 1) return KD;
        if (step == 2) return KE;
        if (step == 3 && (op == OP_LW || op == OP_SW)) return KM;
        return KW;
    endfunction

    function automatic out_t model_out();
        out_t e;
        int   k;
        e       = '0;
        e.busy  = (m_mode == MRun);
        e.trap  = (m_mode == MTrap);
        e.cause = m_cause;
        if (m_mode == MRun) begin
            k = kind_at(m_op, m_step);
            case (k)
                KF: begin e.mem_rd = 1'b1; e.ir_we = bus.mem_ready; end
                KE: e.alusrc = (m_op == OP_I) || (m_op == OP_LW) || (m_op == OP_SW);
                KM: begin
                    e.mem_sel = 1'b1;
                    e.mem_rd  = (m_op == OP_LW);
                    e.mem_wr  = (m_op == OP_SW);
                end
                KW: begin e.reg_we = 1'b1; e.m2r = (m_op == OP_LW); e.wb_pc4 = (m_op == OP_JAL); end
                default: e.busy = 1'b1;
            endcase
            if (m_step >= 2 && m_step == cls_len(m_op) - 1 && (k != KM || bus.mem_ready)) begin
                e.pc_we = 1'b1;
                if (bus.INT)              e.pc_src = 2'b11;
                else if (m_op == OP_BEQ)  e.pc_src = bus.zero ? 2'b01 : 2'b00;
                else if (m_op == OP_JAL)  e.pc_src = 2'b10;
                else                      e.pc_src = 2'b00;
            end
        end
        return e;
    endfunction

    // Instruction-level model, advanced on each clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= MIdle; m_step <= 0; m_wait <= 0;
            m_op <= '0; m_ret <= '0; m_cause <= 2'b00;
        end else if (m_mode == MIdle) begin
            if (bus.run) begin m_mode <= MRun; m_step <= 0; m_wait <= 0; end
        end else if (m_mode == MRun) begin
            if ((kind_at(m_op, m_step) == KF || kind_at(m_op, m_step) == KM) && !bus.mem_ready) begin
                if (m_wait == TIMEOUT - 1) begin m_mode <= MTrap; m_cause <= 2'b10; end
                else m_wait <= m_wait + 1;
            end else begin
                m_wait <= 0;
                if (m_step == 1) begin
                    m_op <= bus.opCode;
                    if (cls_len(bus.opCode) == 0) begin m_mode <= MTrap; m_cause <= 2'b01; end
                    else m_step <= 2;
                end else if (m_step == cls_len(m_op) - 1) begin
                    m_ret  <= m_ret + 1;
                    m_step <= 0;
                    m_mode <= bus.run ? MRun : MIdle;
                end else begin
                    m_step <= m_step + 1;
                end
            end
        end
    end

    task automatic compare_all();
        out_t e;
        e = model_out();
        chk("mem_sel", bus.mem_sel, e.mem_sel);
        chk("mem_rd", bus.mem_rd, e.mem_rd);
        chk("mem_wr", bus.mem_wr, e.mem_wr);
        chk("ir_we", bus.ir_we, e.ir_we);
        chk("reg_we", bus.reg_we, e.reg_we);
        chk("Mem2Reg", bus.Mem2Reg, e.m2r);
        chk("wb_pc4", bus.wb_pc4, e.wb_pc4);
        chk("ALUSrc", bus.ALUSrc, e.alusrc);
        chk("pc_we", bus.pc_we, e.pc_we);
        chk("pc_src", bus.pc_src, e.pc_src);
        chk("busy", bus.busy, e.busy);
        chk("trap", bus.trap, e.trap);
        chk("trap_cause", bus.trap_cause, e.cause);
        chk("retired", bus.retired, m_ret);
    endtask

    always @(negedge clk) begin
        if (chk_on) compare_all();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.run = 1'b0; bus.INT = 1'b0; bus.opCode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one instruction from IDLE; run drops from DECODE onward when run_after=0
    task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait,
                             input logic z, input logic intr, input logic run_after,
                             output obs_t o);
        int fc, mc, n;
        bit done;
        o = '{default: 0};
        fc = 0; mc = 0; n = 0; done = 1'b0;
        bus.run = 1'b1; bus.opCode = op; bus.zero = z; bus.INT = intr; bus.mem_ready = 1'b1;
        tick();
        while (!done && n < 60) begin
            n++;
            bus.run = (n >= 2) ? run_after : 1'b1;
            if (bus.mem_rd && !bus.mem_sel) begin bus.mem_ready = (fc >= fwait); fc++; end
            else if (bus.mem_sel) begin bus.mem_ready = (mc >= mwait); mc++; end
            else bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.ir_we && o.first_ir == 0) o.first_ir = n;
            if (bus.mem_sel && bus.mem_rd) o.n_mem_rd++;
            if (bus.mem_wr) o.n_mem_wr++;
            if (bus.reg_we) o.n_reg_we++;
            if (bus.pc_we) begin
                o.n_pc_we++;
                o.ret_reg_we = bus.reg_we; o.ret_m2r = bus.Mem2Reg;
                o.ret_wb_pc4 = bus.wb_pc4; o.ret_src = bus.pc_src;
                done = 1'b1;
            end
            if (bus.trap) begin o.saw_trap = 1'b1; done = 1'b1; end
            tick();
        end
        o.cycles  = n;
        o.n_fetch = fc;
        if (!done) chk("instr_bound", 32'd0, 32'd1);
    endtask

    logic [6:0] legal [6] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL};

    initial begin
        obs_t o;
        int   rdy_pct, r;
        do_reset();
        chk_on = 1'b1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_trap", bus.trap, 0);
        chk("rst_cause", bus.trap_cause, 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_pc_we", bus.pc_we, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);

        // R-type, always ready
        run_instr(OP_R, 0, 0, 1'b0, 1'b0, 1'b0, o);
        chk("r_ir_cycle", o.first_ir, 1);
        chk("r_cycles", o.cycles, 4);
        chk("r_ret_reg_we", o.ret_reg_we, 1);
        chk("r_ret_src", o.ret_src, 0);
        chk("r_retired", bus.retired, 1);
        chk("r_idle_busy", bus.busy, 0);
        chk("model_ret_r", m_ret, 1);

        // LW with memory stalled 3 cycles in MEM
        run_instr(OP_LW, 0, 3, 1'b0, 1'b0, 1'b0, o);
        chk("lw_cycles", o.cycles, 8);
        chk("lw_mem_rd_cycles", o.n_mem_rd, 4);
        chk("lw_ret_m2r", o.ret_m2r, 1);
        chk("lw_ret_reg_we", o.ret_reg_we, 1);
        chk("lw_retired", bus.retired, 2);

        // BEQ taken then not taken
        do_reset();
        run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0, 1'b0, o);
        chk("beq1_cycles", o.cycles, 3);
        chk("beq1_src", o.ret_src, 1);
        chk("beq1_reg_we", o.n_reg_we, 0);
        run_instr(OP_BEQ, 0, 0, 1'b0, 1'b0, 1'b0, o);
        chk("beq0_src", o.ret_src, 0);
        chk("beq0_reg_we", o.n_reg_we, 0);
        chk("beq_retired", bus.retired, 2);

        // JAL with interrupt at retire
        run_instr(OP_JAL, 0, 0, 1'b0, 1'b1, 1'b0, o);
        chk("jal_cycles", o.cycles, 4);
        chk("jal_reg_we", o.ret_reg_we, 1);
        chk("jal_wb_pc4", o.ret_wb_pc4, 1);
        chk("jal_src", o.ret_src, 3);
        chk("jal_pc_we", o.n_pc_we, 1);

        // Illegal opcode
        run_instr(7'b1111111, 0, 0, 1'b0, 1'b0, 1'b0, o);
        chk("ill_trap", o.saw_trap, 1);
        chk("ill_cycles", o.cycles, 3);
        chk("ill_pc_we", o.n_pc_we, 0);
        chk("ill_reg_we", o.n_reg_we, 0);
        chk("ill_mem_wr", o.n_mem_wr, 0);
        chk("ill_cause", bus.trap_cause, 1);
        chk("ill_retired", bus.retired, 3);

        // Fetch timeout
        do_reset();
        run_instr(OP_R, 1000, 0, 1'b0, 1'b0, 1'b1, o);
        chk("to_trap", o.saw_trap, 1);
        chk("to_fetch_cycles", o.n_fetch, 16);
        chk("to_cycles", o.cycles, 17);
        chk("to_cause", bus.trap_cause, 2);
        bus.run = 1'b1; bus.INT = 1'b1; bus.mem_ready = 1'b1;
        repeat (3) tick();
        chk("trap_sticky", bus.trap, 1);
        chk("trap_busy", bus.busy, 0);
        chk("trap_pc_we", bus.pc_we, 0);

        // Reset in the middle of a store
        do_reset();
        run_instr(OP_R, 0, 0, 1'b0, 1'b0, 1'b0, o);
        chk("pre_sw_retired", bus.retired, 1);
        bus.run = 1'b1; bus.opCode = OP_SW; bus.mem_ready = 1'b1; bus.INT = 1'b0;
        repeat (4) tick();
        bus.mem_ready = 1'b0;
        chk("sw_mem_wr_pre", bus.mem_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("sw_rst_mem_wr", bus.mem_wr, 0);
        chk("sw_rst_mem_sel", bus.mem_sel, 0);
        chk("sw_rst_busy", bus.busy, 0);
        chk("sw_rst_retired", bus.retired, 0);
        bus.run = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        chk("sw_after_busy", bus.busy, 0);

        // Randomized traffic
        do_reset();
        rdy_pct = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                r = $urandom_range(0, 2);
                rdy_pct = (r == 0) ? 100 : (r == 1) ? 75 : 3;
            end
            bus.run = ($urandom_range(0, 99) < 90);
            r = $urandom_range(0, 99);
            bus.opCode = (r < 94) ? legal[r % 6] : 7'($urandom_range(0, 127));
            bus.zero = 1'($urandom_range(0, 1));
            bus.INT = ($urandom_range(0, 99) < 20);
            bus.mem_ready = ($urandom_range(0, 99) < rdy_pct);
            if ((bus.trap && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                rst_n = 1'b0;
            else
                rst_n = 1'b1;
            tick();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
